// File: rtl/dpram_rd_stream.sv
// rtl/dpram_rd_stream.sv - RAM read-port engine turning (addr, len) commands into a valid/ready stream
module dpram_rd_stream #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int RAM_DEPTH  = 1024,
    parameter int OUT_DELAY  = 1,
    parameter int LEN_WIDTH  = 11
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
    input  logic [LEN_WIDTH-1:0]  i_cmd_len,
    output logic                  o_en_b,
    output logic [ADDR_WIDTH-1:0] o_addr_b,
    input  logic [DATA_WIDTH-1:0] i_data_b,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_last,
    output logic                  o_busy,
    output logic                  o_done
);

    // Skid FIFO holds every read that can be in flight plus one beat of slack
    // so a read can be issued in the same cycle a beat leaves.
    localparam int FIFO_DEPTH = OUT_DELAY + 2;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam int SUM_W      = $clog2(2 * FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [ADDR_WIDTH-1:0]  r_addr_hold;
    logic [LEN_WIDTH-1:0]   r_remaining;
    logic                   r_zero_done;
    logic [OUT_DELAY-1:0]   r_fl_valid;
    logic [OUT_DELAY-1:0]   r_fl_last;
    logic [DATA_WIDTH-1:0]  r_fifo_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]  r_fifo_last;
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [CNT_W-1:0]       r_count;

    logic                   w_pop;
    logic                   w_en;
    logic                   w_credit;
    logic                   w_issue_last;
    logic                   w_tail_wr;
    logic                   w_last_pop;
    logic [SUM_W-1:0]       w_in_flight;
    logic [ADDR_WIDTH-1:0]  w_addr_next;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_cmd_ready  = (r_state == S_IDLE);
    assign o_busy       = (r_state != S_IDLE);
    assign o_valid      = (r_count != '0);
    assign o_data       = o_valid ? r_fifo_data[r_rd_ptr] : '0;
    assign o_last       = o_valid ? r_fifo_last[r_rd_ptr] : 1'b0;
    assign w_pop        = o_valid & i_ready;
    assign w_tail_wr    = r_fl_valid[OUT_DELAY-1];
    assign w_issue_last = (r_remaining == LEN_WIDTH'(1));
    assign w_addr_next  = (r_addr == ADDR_WIDTH'(RAM_DEPTH - 1)) ? '0 : r_addr + 1'b1;
    assign w_last_pop   = (r_state == S_DRAIN) & w_pop & o_last;
    assign o_done       = r_zero_done | w_last_pop;

    // Count reads issued but not yet returned by the RAM
    always_comb begin
        w_in_flight = '0;
        for (int i = 0; i < OUT_DELAY; i++) begin
            w_in_flight = w_in_flight + SUM_W'(r_fl_valid[i]);
        end
    end

    // A read may only be issued when its data is guaranteed a FIFO slot
    assign w_credit = (w_in_flight + SUM_W'(r_count)) < (SUM_W'(FIFO_DEPTH) + SUM_W'(w_pop));
    assign w_en     = (r_state == S_READ) & w_credit;
    assign o_en_b   = w_en;
    assign o_addr_b = w_en ? r_addr : r_addr_hold;

    // Command FSM state register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Command FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_cmd_valid && (i_cmd_len != '0)) w_state_nxt = S_READ;
            S_READ:  if (w_en && w_issue_last)             w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_last_pop)                       w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Command latch, address walk and remaining-word counter
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_addr      <= '0;
            r_addr_hold <= '0;
            r_remaining <= '0;
            r_zero_done <= 1'b0;
        end else begin
            r_addr_hold <= o_addr_b;
            r_zero_done <= (r_state == S_IDLE) & i_cmd_valid & (i_cmd_len == '0);
            if ((r_state == S_IDLE) && i_cmd_valid) begin
                r_addr      <= i_cmd_addr;
                r_remaining <= i_cmd_len;
            end else if (w_en) begin
                r_addr      <= w_addr_next;
                r_remaining <= r_remaining - 1'b1;
            end
        end
    end

    // In-flight {valid, last} shift register mirroring the RAM read latency
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fl_valid <= '0;
            r_fl_last  <= '0;
        end else begin
            r_fl_valid[0] <= w_en;
            r_fl_last[0]  <= w_en & w_issue_last;
            for (int i = 1; i < OUT_DELAY; i++) begin
                r_fl_valid[i] <= r_fl_valid[i-1];
                r_fl_last[i]  <= r_fl_last[i-1];
            end
        end
    end

    // Skid FIFO storage; contents need no reset since occupancy gates the outputs
    always_ff @(posedge i_clk) begin
        if (w_tail_wr) begin
            r_fifo_data[r_wr_ptr] <= i_data_b;
        end
    end

    // Skid FIFO pointers, occupancy and last flags
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_fifo_last <= '0;
        end else begin
            if (w_tail_wr) begin
                r_fifo_last[r_wr_ptr] <= r_fl_last[OUT_DELAY-1];
                r_wr_ptr              <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            r_count <= r_count + CNT_W'(w_tail_wr) - CNT_W'(w_pop);
        end
    end

endmodule

// File: doc/dpram_rd_stream.md
Name: dpram_rd_stream

Overview:
- Read-side engine for the dual-port RAM. It drives the RAM's read port (enable, address) and accepts the read data returned OUT_DELAY cycles later.
- It converts a (start address, length) command into a valid/ready data stream with a last flag.
- It absorbs the RAM read latency with an internal skid FIFO, so downstream backpressure never loses a word.
- It sits between a packet/descriptor buffer written on port A and a downstream streaming consumer.

Parameters:
- DATA_WIDTH, 32, RAM word width.
- ADDR_WIDTH, 10, RAM address width.
- RAM_DEPTH, 1024, number of RAM words; the address wraps modulo this value.
- OUT_DELAY, 1, RAM read latency in cycles from enable to data (must be >= 1).
- LEN_WIDTH, 11, width of the command length in words.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous reset, active-high.
- i_cmd_valid  in  1  command request.
- o_cmd_ready  out  1  command can be accepted; high only in IDLE.
- i_cmd_addr  in  ADDR_WIDTH  start word address.
- i_cmd_len  in  LEN_WIDTH  number of words, 0..RAM_DEPTH.
- o_en_b  out  1  RAM read enable.
- o_addr_b  out  ADDR_WIDTH  RAM read address.
- i_data_b  in  DATA_WIDTH  RAM read data, valid OUT_DELAY cycles after o_en_b.
- o_valid  out  1  stream data valid.
- i_ready  in  1  downstream accepts.
- o_data  out  DATA_WIDTH  stream data.
- o_last  out  1  final word of the command.
- o_busy  out  1  command in progress (state != IDLE).
- o_done  out  1  one-cycle pulse when the last word is accepted, or when a len-0 command is accepted.

Behaviour:
- Reset: all outputs 0 except o_cmd_ready = 1; state IDLE; FIFO emptied; in-flight tracking cleared.
- Reset mid-operation: the same clear applies. RAM data returning after reset is discarded.
- FIFO depth = OUT_DELAY + 2. It is show-ahead: o_data/o_last are driven from the head entry, and o_valid = FIFO non-empty.
- In-flight tracking: an OUT_DELAY-deep shift register of {valid, last}. Entry 0 is loaded by o_en_b. The tail entry, when valid, writes {i_data_b, last} into the FIFO that cycle.
- Credit rule: o_en_b may assert only when in_flight + fifo_count + (pop ? -1 : 0) < FIFO depth. The FIFO therefore never overflows and i_data_b is never dropped.
- State IDLE:
  - o_cmd_ready = 1.
  - On i_cmd_valid with len > 0: latch addr and remaining = len; go to READ.
  - On len = 0: pulse o_done next cycle; stay IDLE.
- State READ:
  - Each cycle the credit allows, assert o_en_b with o_addr_b = current address.
  - Advance address: addr + 1, or 0 when addr == RAM_DEPTH-1.
  - Decrement remaining. The read issued when remaining == 1 carries last = 1.
  - After the last read is issued, go to DRAIN.
- State DRAIN:
  - o_en_b = 0.
  - When a beat with o_last is accepted (o_valid & i_ready & o_last), pulse o_done and go to IDLE.
- Beat transfer happens on o_valid & i_ready. o_valid, o_data and o_last must be held stable while o_valid & !i_ready.
- Latency: command accepted at cycle T gives first o_en_b at T+1, FIFO write at T+1+OUT_DELAY, and first o_valid at T+2+OUT_DELAY.
- Throughput: with i_ready held high, one word per cycle sustained; no bubbles after the first.
- Command overlap: the next command is accepted only in IDLE, so back-to-back commands have a gap of at least one idle cycle. o_cmd_ready rises the cycle after o_done.
- Length RAM_DEPTH: reads every word exactly once, starting at addr, wrapping through 0.
- Commands with i_cmd_len > RAM_DEPTH are illegal. Behaviour is unspecified, but the bench asserts they are never issued.
- o_addr_b holds its last value when o_en_b = 0.

Test Plan:
- Basic burst, OUT_DELAY=1, i_ready=1: RAM preloaded with mem[a]=a+0x100; command addr 0x010, len 4 → o_en_b high 4 consecutive cycles at addresses 0x10..0x13. Stream is 0x110, 0x111, 0x112, 0x113, with o_last on the 4th word. First o_valid is 3 cycles after command accept; o_done pulses with the last beat.
- Backpressure: same command with i_ready toggling 1,0,0,1,... → all 4 words delivered in order with no loss or duplication. o_data is stable while stalled; o_en_b never pushes in_flight + fifo_count beyond 3.
- Wrap-around, RAM_DEPTH=1024: addr 0x3FE, len 4 → read addresses 0x3FE, 0x3FF, 0x000, 0x001; data order matches.
- Zero length: len 0 → no o_en_b, no o_valid, o_done pulses once, o_cmd_ready stays high.
- Reset mid-burst: len 8 with i_rst asserted after 3 beats → next cycle all outputs 0 and o_cmd_ready=1. A new command addr 0, len 2 then yields exactly mem[0], mem[1] with no stale words.
- OUT_DELAY=3 with random i_ready over 1000 random commands (len 0..64): a scoreboard matches every word and every last flag. No FIFO overflow assertion ever fires; full throughput when i_ready=1.
